// File: rtl/divisor_secuencial_4b_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM encoding.
package divisor_secuencial_4b_pkg;

  localparam int ANCHO_DEF = 4;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estadoT;

endpackage

// File: rtl/divisor_secuencial_4b_restador.sv
// Ripple subtractor for the divider datapath, chained from the same fullAdder cell as the adder.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic s,
  output logic cOut
);
  assign s    = a ^ b ^ cIn;
  assign cOut = (a & b) | (cIn & (a ^ b));
endmodule

module restador_nb #(
  parameter int N = 5
) (
  input  logic [N-1:0] minuendo,
  input  logic [N-1:0] sustraendo,
  output logic [N-1:0] diferencia,
  output logic         acarreo
);
  logic [N:0] c;

  // Two's complement subtraction: invert the subtrahend and inject 1 as carry-in.
  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : gBit
    fullAdder uFa (
      .a   (minuendo[i]),
      .b   (~sustraendo[i]),
      .cIn (c[i]),
      .s   (diferencia[i]),
      .cOut(c[i+1])
    );
  end

  assign acarreo = c[N];
endmodule

// File: rtl/divisor_secuencial_4b.sv
// Multi-cycle restoring unsigned divider: one shift-and-subtract step per clock, listo strobe on completion.
module divisor_secuencial_4b
  import divisor_secuencial_4b_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [ANCHO-1:0] dividendo,
  input  logic [ANCHO-1:0] divisor,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             errorDiv0
);
  localparam int CW = $clog2(ANCHO + 1);

  estadoT           estado, estadoSig;
  logic [ANCHO:0]   rReg, rDesp, dif;
  logic [ANCHO-1:0] qReg, dReg;
  logic [CW-1:0]    cnt;
  logic             esDiv0, acarreo, acepta;

  // The listo cycle is spent back in REPOSO but still counts as busy, so gate on ocupado too.
  assign acepta = (estado == REPOSO) && inicio && !ocupado;
  assign rDesp  = {rReg[ANCHO-1:0], qReg[ANCHO-1]};

  restador_nb #(.N(ANCHO + 1)) uRest (
    .minuendo  (rDesp),
    .sustraendo({1'b0, dReg}),
    .diferencia(dif),
    .acarreo   (acarreo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estadoSig;
  end

  always_comb begin
    estadoSig = estado;
    case (estado)
      REPOSO:  if (acepta) estadoSig = (divisor == '0) ? FIN : CALCULO;
      CALCULO: if (cnt == CW'(1)) estadoSig = FIN;
      FIN:     estadoSig = REPOSO;
      default: estadoSig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rReg      <= '0;
      qReg      <= '0;
      dReg      <= '0;
      cnt       <= '0;
      esDiv0    <= 1'b0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      cociente  <= '0;
      residuo   <= '0;
      errorDiv0 <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (listo) ocupado <= 1'b0;
      case (estado)
        REPOSO: if (acepta) begin
          qReg      <= dividendo;
          rReg      <= '0;
          dReg      <= divisor;
          cnt       <= CW'(ANCHO);
          esDiv0    <= (divisor == '0);
          errorDiv0 <= 1'b0;
          ocupado   <= 1'b1;
        end
        CALCULO: begin
          // Carry out means no borrow: keep the difference and shift in a quotient 1.
          rReg <= acarreo ? dif : rDesp;
          qReg <= {qReg[ANCHO-2:0], acarreo};
          cnt  <= cnt - 1'b1;
        end
        FIN: begin
          listo     <= 1'b1;
          cociente  <= esDiv0 ? '1 : qReg;
          residuo   <= esDiv0 ? qReg : rReg[ANCHO-1:0];
          errorDiv0 <= esDiv0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor_secuencial_4b.sv
// Directed and sweep checks of the sequential divider: latency, results, div-by-zero, busy and reset handling.
module tb_divisor_secuencial_4b;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inicio = 1'b0;
  logic [3:0] dividendo = '0, divisor = '0;
  logic       ocupado, listo, errorDiv0;
  logic [3:0] cociente, residuo;

  int nTests = 0;
  int nFail  = 0;

  divisor_secuencial_4b dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inicio   (inicio),
    .dividendo(dividendo),
    .divisor  (divisor),
    .ocupado  (ocupado),
    .listo    (listo),
    .cociente (cociente),
    .residuo  (residuo),
    .errorDiv0(errorDiv0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with inicio for one cycle; returns at the negedge after the accept edge.
  task automatic startOp(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    dividendo = a;
    divisor   = b;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
  endtask

  // Counts edges after the accept edge until listo is seen; bounded.
  task automatic waitListo(output int n);
    n = 0;
    while (!listo && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  int lat, pulses;
  logic [3:0] expQ, expR;
  logic       expE;

  initial begin
    // Reset state
    #12;
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", listo, 0);
    chk("rst_cociente", cociente, 0);
    chk("rst_residuo", residuo, 0);
    chk("rst_error", errorDiv0, 0);
    rst_n = 1'b1;

    // 1. 13/3, operands scrambled after acceptance
    startOp(4'd13, 4'd3);
    chk("t1_ocupado", ocupado, 1);
    dividendo = 4'd0; divisor = 4'd7;
    waitListo(lat);
    chk("t1_lat", lat, 5);
    chk("t1_q", cociente, 4);
    chk("t1_r", residuo, 1);
    chk("t1_e", errorDiv0, 0);
    chk("t1_ocupListo", ocupado, 1);
    @(negedge clk);
    chk("t1_pulse", listo, 0);
    chk("t1_idle", ocupado, 0);

    // 2. Boundary patterns
    startOp(4'd15, 4'd1); waitListo(lat);
    chk("t2a_q", cociente, 15); chk("t2a_r", residuo, 0);
    startOp(4'd0, 4'd5); waitListo(lat);
    chk("t2b_q", cociente, 0); chk("t2b_r", residuo, 0);
    startOp(4'd7, 4'd9); waitListo(lat);
    chk("t2c_q", cociente, 0); chk("t2c_r", residuo, 7);

    // 3. Divide by zero, then a normal divide clears the flag
    startOp(4'd9, 4'd0); waitListo(lat);
    chk("t3_lat", lat, 1);
    chk("t3_e", errorDiv0, 1);
    chk("t3_q", cociente, 15);
    chk("t3_r", residuo, 9);
    startOp(4'd8, 4'd2);
    chk("t3_eClr", errorDiv0, 0);
    waitListo(lat);
    chk("t3b_lat", lat, 5);
    chk("t3b_q", cociente, 4); chk("t3b_r", residuo, 0);

    // 4. Re-pulse during ocupado is ignored
    startOp(4'd14, 4'd4);
    @(negedge clk);
    dividendo = 4'd6; divisor = 4'd2; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (listo) begin
        pulses++;
        chk("t4_q", cociente, 3);
        chk("t4_r", residuo, 2);
      end
      @(negedge clk);
    end
    chk("t4_pulses", pulses, 1);
    chk("t4_idle", ocupado, 0);

    // 5. Reset during iteration 2 aborts
    startOp(4'd11, 4'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ocupado", ocupado, 0);
    chk("t5_q", cociente, 0);
    chk("t5_r", residuo, 0);
    chk("t5_e", errorDiv0, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (listo) pulses++;
    end
    rst_n = 1'b1;
    chk("t5_noListo", pulses, 0);
    startOp(4'd11, 4'd2); waitListo(lat);
    chk("t5b_lat", lat, 5);
    chk("t5b_q", cociente, 5); chk("t5b_r", residuo, 1);

    // 6. Exhaustive sweep, back-to-back starts
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          expQ = 4'hF; expR = 4'(a); expE = 1'b1;
        end else begin
          expQ = 4'(a / b); expR = 4'(a % b); expE = 1'b0;
        end
        startOp(4'(a), 4'(b));
        waitListo(lat);
        chk($sformatf("sw_lat_%0d_%0d", a, b), lat, (b == 0) ? 1 : 5);
        chk($sformatf("sw_q_%0d_%0d", a, b), cociente, expQ);
        chk($sformatf("sw_r_%0d_%0d", a, b), residuo, expR);
        chk($sformatf("sw_e_%0d_%0d", a, b), errorDiv0, expE);
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
